mdu_unit: RTL

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Returns MFHI/MFLO data into ALUResE, which feeds the EX/MEM pipeline register.
- Raises a busy flag that the hazard unit uses to stall any MDU-class instruction held in EX.

---
 rtl/mdu_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU with fixed latency and serves MTHI/MTLO/MFHI/MFLO.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (opcodes 9-12).
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        ExcKill,
  output logic        MDUBusy,
  output logic [31:0] MDUResE,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi;
  logic [31:0]      lo;

  logic        start_op;
  logic        start;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] next_hilo;

  // Classify the EX opcode as one that launches a multi-cycle operation
  always_comb begin
    start_op = 1'b0;
    case (MDUOpE)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_op = 1'b1;
`endif
      default: start_op = 1'b0;
    endcase
  end

  assign start   = (state == IDLE) && start_op && !ExcKill;
  assign is_div  = (MDUOpE == OP_DIV) || (MDUOpE == OP_DIVU);
  assign MDUBusy = start || (state == RUN);
  assign HIOut   = hi;
  assign LOOut   = lo;

  // MFHI/MFLO read the architectural registers directly, no bypass
  always_comb begin
    MDUResE = 32'd0;
    if (MDUOpE == OP_MFHI) MDUResE = hi;
    else if (MDUOpE == OP_MFLO) MDUResE = lo;
  end

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide is done on magnitudes so the overflow case falls out naturally
  assign div_signed = (op_q == OP_DIV);
  assign a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
  assign dvd        = div_signed ? a_mag : a_q;
  assign dvs        = div_signed ? b_mag : b_q;
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_u        = dvd / dvs_safe;
  assign r_u        = dvd % dvs_safe;
  assign quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_u) : q_u;
  assign rem        = (div_signed && a_q[31]) ? (32'd0 - r_u) : r_u;

  // Value written into {HI,LO} on the completion edge; accumulate forms read HI/LO now
  always_comb begin
    next_hilo = {hi, lo};
    case (op_q)
      OP_MULT:  next_hilo = prod_s;
      OP_MULTU: next_hilo = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q != 32'd0) next_hilo = {rem, quot};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  next_hilo = {hi, lo} + prod_s;
      OP_MADDU: next_hilo = {hi, lo} + prod_u;
      OP_MSUB:  next_hilo = {hi, lo} - prod_s;
      OP_MSUBU: next_hilo = {hi, lo} - prod_u;
`endif
      default:  next_hilo = {hi, lo};
    endcase
  end

  // Control FSM: launch, count down, and commit HI/LO; MTHI/MTLO only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= MDUOpE;
            a_q     <= SrcAE;
            b_q     <= SrcBE;
            counter <= is_div ? DIV_LOAD : MULT_LOAD;
            state   <= RUN;
          end else if (!ExcKill) begin
            if (MDUOpE == OP_MTHI) hi <= SrcAE;
            if (MDUOpE == OP_MTLO) lo <= SrcAE;
          end
        end
        RUN: begin
          counter <= counter - CNT_ONE;
          if (counter == CNT_ONE) begin
            {hi, lo} <= next_hilo;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
